// File: rtl/boot_data_loader.sv
// rtl/boot_data_loader.sv - byte-stream boot loader that fills CPU data memory, then releases CPU reset
//
// Purpose: accepts a little-endian byte stream made of a 4-byte word-count header
// followed by that many payload words. Each payload word is written through the
// CPU's external memory-load port while the CPU is held in reset. The CPU is
// released once the last word has been written.
//
// Optional build macro: BOOT_LOADER_CHECKSUM_EN
//   When defined, one trailing byte must equal the XOR of all header and payload
//   bytes. A match ends in DONE; a mismatch ends in ERR.
//   When undefined, the loader goes straight to DONE. The port list is identical
//   in both builds.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   in_valid, in_data      incoming byte stream
//   in_ready               registered ready, decoded from the FSM state only
//   reload                 one-cycle pulse; restarts loading from DONE or ERR
//   Ext_MemWrite           data memory write strobe (high only in WRITE)
//   Ext_WriteData          word to write
//   Ext_DataAdr            byte address of that word
//   cpu_reset              CPU reset; stays high until the load completes
//   load_done, load_err    status flags for successful or aborted loads
module boot_data_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [31:0] MaxCount = 32'(MAX_WORDS);

`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, DATA, WRITE, CHK, DONE, ERR} state_t;
  localparam state_t AfterLast = CHK;
`else
  typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERR} state_t;
  localparam state_t AfterLast = DONE;
`endif

  state_t      state, nextState;
  logic [1:0]  byteCnt;
  logic [23:0] asmWord;    // first three bytes of the current word, byte 0 in [7:0]
  logic [31:0] wordCount;
  logic [31:0] idx;
  logic        accept;
  logic        fillByte;
  logic [31:0] fullWord;
  logic [31:0] idxNext;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]  xorAcc;
`endif

  assign accept   = in_valid && in_ready;
  assign fillByte = accept && ((state == HDR) || (state == DATA));
  assign fullWord = {in_data, asmWord};
  assign idxNext  = idx + 32'd1;

  always_comb begin
    nextState = state;
    case (state)
      HDR: begin
        if (fillByte && (byteCnt == 2'd3)) begin
          if (fullWord == 32'd0)
            nextState = AfterLast;
          else if (fullWord > MaxCount)
            nextState = ERR;
          else
            nextState = DATA;
        end
      end
      DATA: begin
        if (fillByte && (byteCnt == 2'd3))
          nextState = WRITE;
      end
      WRITE: begin
        nextState = (idxNext == wordCount) ? AfterLast : DATA;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept)
          nextState = (in_data == xorAcc) ? DONE : ERR;
      end
`endif
      DONE, ERR: begin
        if (reload)
          nextState = HDR;
      end
      default: nextState = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= HDR;
      byteCnt       <= 2'd0;
      asmWord       <= 24'd0;
      wordCount     <= 32'd0;
      idx           <= 32'd0;
      in_ready      <= 1'b1;
      Ext_MemWrite  <= 1'b0;
      Ext_WriteData <= 32'd0;
      Ext_DataAdr   <= BASE_ADDR;
      cpu_reset     <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      xorAcc        <= 8'd0;
`endif
    end else begin
      state <= nextState;

      // All status outputs are decoded from the next state so they take effect
      // on the first cycle in the new state, with no path from in_valid.
      in_ready <= (nextState == HDR) || (nextState == DATA)
`ifdef BOOT_LOADER_CHECKSUM_EN
                  || (nextState == CHK)
`endif
                  ;
      Ext_MemWrite <= (nextState == WRITE);
      cpu_reset    <= (nextState != DONE);
      load_done    <= (nextState == DONE);
      load_err     <= (nextState == ERR);

      if (fillByte) begin
        byteCnt <= byteCnt + 2'd1;
        asmWord <= {in_data, asmWord[23:8]};  // shift in from the top; byte 0 settles in [7:0]
`ifdef BOOT_LOADER_CHECKSUM_EN
        xorAcc  <= xorAcc ^ in_data;
`endif
      end

      if (fillByte && (byteCnt == 2'd3) && (state == HDR))
        wordCount <= fullWord;

      if (fillByte && (byteCnt == 2'd3) && (state == DATA)) begin
        Ext_WriteData <= fullWord;
        Ext_DataAdr   <= BASE_ADDR + (idx << 2);
      end

      if (state == WRITE)
        idx <= idxNext;

      if (((state == DONE) || (state == ERR)) && reload) begin
        idx     <= 32'd0;
        byteCnt <= 2'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        xorAcc  <= 8'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_boot_data_loader.sv
// tb/tb_boot_data_loader.sv - table-driven scoreboard bench for boot_data_loader
module tb_boot_data_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit ChkBuild = 1'b1;
`else
  localparam bit ChkBuild = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        reload = 1'b0;
  logic        in_ready;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  boot_data_loader #(.BASE_ADDR(BASE), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .Ext_MemWrite(Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData), .Ext_DataAdr(Ext_DataAdr),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    int          gap;
    bit          fixedData;
    bit          badSum;
  } vec_t;

  wr_t  expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   writesSeen = 0;
  bit   prevMw = 1'b0;
  logic [7:0] runXor;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (Ext_MemWrite === 1'b1) begin
      wr_t e;
      writesSeen++;
      check("mw_single_cycle", 32'(prevMw), 32'd0);
      check("write_in_ready", 32'(in_ready), 32'd0);
      check("write_cpu_reset", 32'(cpu_reset), 32'd1);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got adr %h data %h expected no write", Ext_DataAdr, Ext_WriteData);
      end else begin
        e = expQ.pop_front();
        check("write_adr", Ext_DataAdr, e.adr);
        check("write_data", Ext_WriteData, e.data);
      end
    end
    prevMw = Ext_MemWrite;
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    runXor = runXor ^ b;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] t;
      t = w >> (8 * k);
      sendByte(t[7:0], gap);
    end
  endtask

  task automatic runStream(input vec_t v);
    bit expDone;
    int expWrites;
    int w;
    logic [31:0] word;
    runXor = 8'd0;
    writesSeen = 0;
    expDone = (v.n <= 32'd64) && !(ChkBuild && v.badSum);
    expWrites = (v.n <= 32'd64) ? int'(v.n) : 0;
    sendWord(v.n, v.gap);
    if (v.n <= 32'd64) begin
      for (int i = 0; i < int'(v.n); i++) begin
        if (v.fixedData) word = (i == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
        else word = $urandom;
        expQ.push_back('{adr: BASE + 32'(i) * 32'd4, data: word});
        sendWord(word, v.gap);
      end
      if (ChkBuild) sendByte(v.badSum ? (runXor ^ 8'h01) : runXor, 0);
    end
    in_valid = 1'b0;
    w = 0;
    while (!(load_done || load_err) && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("load_done", 32'(load_done), 32'(expDone));
    check("load_err", 32'(load_err), 32'(!expDone));
    check("cpu_reset", 32'(cpu_reset), 32'(!expDone));
    check("in_ready_idle", 32'(in_ready), 32'd0);
    check("write_count", 32'(writesSeen), 32'(expWrites));
    check("queue_empty", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  task automatic doReload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_done", 32'(load_done), 32'd0);
    check("reload_err", 32'(load_err), 32'd0);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_mw"}, 32'(Ext_MemWrite), 32'd0);
    check({tag, "_wdata"}, Ext_WriteData, 32'd0);
    check({tag, "_adr"}, Ext_DataAdr, BASE);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{n: 32'd2,          gap: 0, fixedData: 1'b1, badSum: 1'b0};  // basic load
    vecs[1] = '{n: 32'd0,          gap: 0, fixedData: 1'b0, badSum: 1'b0};  // empty
    vecs[2] = '{n: 32'd65,         gap: 0, fixedData: 1'b0, badSum: 1'b0};  // oversize
    vecs[3] = '{n: 32'd2,          gap: 3, fixedData: 1'b1, badSum: 1'b0};  // gapped
    vecs[4] = '{n: 32'd64,         gap: 0, fixedData: 1'b0, badSum: 1'b0};  // max size
    vecs[5] = '{n: 32'd1,          gap: 1, fixedData: 1'b0, badSum: 1'b1};  // bad sum in checksum build
    vecs[6] = '{n: 32'h0000_0100,  gap: 0, fixedData: 1'b0, badSum: 1'b0};  // byte order: 256
    vecs[7] = '{n: 32'h8000_0001,  gap: 0, fixedData: 1'b0, badSum: 1'b0};  // huge count

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("post_reset");

    for (int i = 0; i < 8; i++) begin
      runStream(vecs[i]);
      doReload();
    end

`ifndef BOOT_LOADER_CHECKSUM_EN
    // Empty load: DONE must be visible right after the edge taking the 4th byte.
    runXor = 8'd0;
    writesSeen = 0;
    sendWord(32'd0, 0);
    in_valid = 1'b0;
    check("empty_done_now", 32'(load_done), 32'd1);
    check("empty_cpu_reset", 32'(cpu_reset), 32'd0);
    repeat (3) @(negedge clk);
    check("empty_no_writes", 32'(writesSeen), 32'd0);
    doReload();
`endif

    // Reset mid-load, after a completed load left nonzero write data behind.
    runStream(vecs[0]);
    doReload();
    runXor = 8'd0;
    sendWord(32'd2, 0);
    sendByte(8'hEF, 0);
    sendByte(8'hBE, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetValues("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    runStream(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
